// File: rtl/scan_display_ctrl.sv
// scan_display_ctrl
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment
// display. Drives the select input of a 3-to-8 active-low decoder, emits the
// active-low segment pattern for the selected digit, inserts a guard-blank
// interval before every digit, and double-buffers the display contents so a
// new image only takes effect at a frame boundary (or straight away in IDLE).
module scan_display_ctrl #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 4,
    parameter int DIGITS       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    input  logic [7:0]  mask,
    input  logic        load,
    output logic        load_ack,
    output logic [2:0]  sel,
    output logic        dig_en,
    output logic [7:0]  seg_n,
    output logic        frame_done
);

    // One counter serves both BLANK and SHOW, so it is sized for the longer one.
    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       SEL_LAST   = 3'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       sel_reg, sel_next;
    logic [7:0]       seg_n_reg, seg_n_next;
    logic             dig_en_reg, dig_en_next;
    logic             load_ack_reg, load_ack_next;
    logic             frame_done_reg, frame_done_next;

    // Hold buffer (written by load) and active buffer (what is displayed).
    logic [31:0]      hold_data_reg, act_data_reg;
    logic [7:0]       hold_dp_reg, act_dp_reg;
    logic [7:0]       hold_mask_reg, act_mask_reg;
    logic             pending_reg, pending_next;
    logic             transfer;

    logic [3:0]       nibble;

    // Hex digit to active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] enc(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0:    r = 7'h40;
            4'h1:    r = 7'h79;
            4'h2:    r = 7'h24;
            4'h3:    r = 7'h30;
            4'h4:    r = 7'h19;
            4'h5:    r = 7'h12;
            4'h6:    r = 7'h02;
            4'h7:    r = 7'h78;
            4'h8:    r = 7'h00;
            4'h9:    r = 7'h10;
            4'hA:    r = 7'h08;
            4'hB:    r = 7'h03;
            4'hC:    r = 7'h46;
            4'hD:    r = 7'h21;
            4'hE:    r = 7'h06;
            default: r = 7'h0E;
        endcase
        return r;
    endfunction

    assign nibble = act_data_reg[{sel_next, 2'b00} +: 4];

    // Next-state, counter, select and registered-output computation.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg + 1'b1;
        sel_next        = sel_reg;
        frame_done_next = 1'b0;
        transfer        = 1'b0;

        if (!en) begin
            // Disable wins from any state; the hold/pending pair survives so
            // an outstanding load is still delivered from IDLE.
            state_next = ST_IDLE;
            cnt_next   = '0;
            sel_next   = 3'd0;
            transfer   = (state_reg == ST_IDLE) && pending_reg;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    sel_next   = 3'd0;
                    transfer   = pending_reg;
                end
                ST_BLANK: begin
                    if (cnt_reg == BLANK_LAST) begin
                        state_next = ST_SHOW;
                        cnt_next   = '0;
                    end
                end
                ST_SHOW: begin
                    if (cnt_reg == SHOW_LAST) begin
                        state_next = ST_BLANK;
                        cnt_next   = '0;
                        if (sel_reg == SEL_LAST) begin
                            sel_next        = 3'd0;
                            frame_done_next = 1'b1;
                            transfer        = pending_reg;
                        end else begin
                            sel_next = sel_reg + 3'd1;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    sel_next   = 3'd0;
                end
            endcase
        end

        // A load in the transfer cycle itself re-arms pending with the new hold.
        pending_next  = load ? 1'b1 : (transfer ? 1'b0 : pending_reg);
        load_ack_next = transfer;

        // Outputs are computed from the next state so they are registered
        // yet line up exactly with the state they belong to.
        seg_n_next  = 8'hFF;
        dig_en_next = 1'b0;
        if (state_next == ST_SHOW) begin
            seg_n_next  = {~act_dp_reg[sel_next], enc(nibble)};
            dig_en_next = act_mask_reg[sel_next];
        end
    end

    // Scan state, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            sel_reg        <= 3'd0;
            seg_n_reg      <= 8'hFF;
            dig_en_reg     <= 1'b0;
            load_ack_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            sel_reg        <= sel_next;
            seg_n_reg      <= seg_n_next;
            dig_en_reg     <= dig_en_next;
            load_ack_reg   <= load_ack_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // Double buffer: load fills hold, transfer copies the pre-edge hold to active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data_reg <= '0;
            hold_dp_reg   <= '0;
            hold_mask_reg <= '0;
            act_data_reg  <= '0;
            act_dp_reg    <= '0;
            act_mask_reg  <= '0;
            pending_reg   <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            if (load) begin
                hold_data_reg <= data;
                hold_dp_reg   <= dp;
                hold_mask_reg <= mask;
            end
            if (transfer) begin
                act_data_reg <= hold_data_reg;
                act_dp_reg   <= hold_dp_reg;
                act_mask_reg <= hold_mask_reg;
            end
        end
    end

    assign sel        = sel_reg;
    assign seg_n      = seg_n_reg;
    assign dig_en     = dig_en_reg;
    assign load_ack   = load_ack_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Directed testbench for scan_display_ctrl with CLK_DIV=4, BLANK_CYCLES=2,
// DIGITS=8: digit period 6 cycles, frame period 48 cycles.
module tb_scan_display_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  mask;
    logic        load;
    logic        load_ack;
    logic [2:0]  sel;
    logic        dig_en;
    logic [7:0]  seg_n;
    logic        frame_done;

    int n_cmp;
    int n_err;

    scan_display_ctrl #(
        .CLK_DIV      (4),
        .BLANK_CYCLES (2),
        .DIGITS       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data       (data),
        .dp         (dp),
        .mask       (mask),
        .load       (load),
        .load_ack   (load_ack),
        .sel        (sel),
        .dig_en     (dig_en),
        .seg_n      (seg_n),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rep8(input logic [7:0] b);
        return {8{b}};
    endfunction

    // Load in IDLE: ack appears one edge after the edge that captured load.
    task automatic idle_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] m);
        data = d;
        dp   = p;
        mask = m;
        load = 1'b1;
        step();
        load = 1'b0;
        check("idle_ack_early", {31'd0, load_ack}, 32'd0);
        step();
        check("idle_ack", {31'd0, load_ack}, 32'd1);
        $display("idle load data=%08h dp=%02h mask=%02h acked=%0b", d, p, m, load_ack);
        step();
        check("idle_ack_end", {31'd0, load_ack}, 32'd0);
    endtask

    // Walk npos cycles of a frame starting at its first BLANK cycle of digit 0,
    // checking every output; optionally pulse load at positions lp1/lp2.
    task automatic run_frame(input logic [63:0] segs, input logic [7:0] msk,
                             input logic fd0, input logic ack0, input int npos,
                             input int lp1, input logic [31:0] ld1,
                             input int lp2, input logic [31:0] ld2);
        int errs_before;
        errs_before = n_err;
        for (int p = 0; p < npos; p++) begin
            int d;
            int c;
            logic [7:0] exp_seg;
            logic       exp_den;
            d = p / 6;
            c = p % 6;
            exp_seg = (c >= 2) ? segs[d*8 +: 8] : 8'hFF;
            exp_den = (c >= 2) ? msk[d] : 1'b0;
            check($sformatf("sel d%0d c%0d", d, c), {29'd0, sel}, d);
            check($sformatf("seg d%0d c%0d", d, c), {24'd0, seg_n}, {24'd0, exp_seg});
            check($sformatf("dig_en d%0d c%0d", d, c), {31'd0, dig_en}, {31'd0, exp_den});
            check($sformatf("frame_done d%0d c%0d", d, c), {31'd0, frame_done},
                  {31'd0, (p == 0) && fd0});
            check($sformatf("load_ack d%0d c%0d", d, c), {31'd0, load_ack},
                  {31'd0, (p == 0) && ack0});
            if (p == lp1) begin
                data = ld1;
                load = 1'b1;
            end else if (p == lp2) begin
                data = ld2;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
        end
        load = 1'b0;
        $display("frame segs=%016h mask=%02h cycles=%0d new_mismatches=%0d",
                 segs, msk, npos, n_err - errs_before);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sel"}, {29'd0, sel}, 32'd0);
        check({tag, "_seg"}, {24'd0, seg_n}, 32'h0000_00FF);
        check({tag, "_dig_en"}, {31'd0, dig_en}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_load_ack"}, {31'd0, load_ack}, 32'd0);
        $display("%s: sel=%0d seg_n=%02h dig_en=%0b", tag, sel, seg_n, dig_en);
    endtask

    logic [63:0] segs_count;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        load  = 1'b0;
        data  = '0;
        dp    = '0;
        mask  = '0;
        // Digits 7..0 showing 7..0 with only digit 0's decimal point lit.
        segs_count = {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'h40};

        step();
        step();
        check_idle("reset");
        rst_n = 1'b1;
        step();

        // Zero contents with every digit enabled: all SHOW cycles read C0.
        idle_load(32'h0, 8'h00, 8'hFF);
        en = 1'b1;
        step();
        run_frame(rep8(8'hC0), 8'hFF, 1'b0, 1'b0, 48, -1, 0, -1, 0);
        run_frame(rep8(8'hC0), 8'hFF, 1'b1, 1'b0, 48, -1, 0, -1, 0);
        check("frame_done_48", {31'd0, frame_done}, 32'd1);
        en = 1'b0;
        step();
        check_idle("en_off_1");

        // IDLE load with counting digits.
        idle_load(32'h7654_3210, 8'h01, 8'hFF);
        en = 1'b1;
        step();
        run_frame(segs_count, 8'hFF, 1'b0, 1'b0, 48, -1, 0, -1, 0);

        // Mid-frame load: old image persists until the boundary.
        dp = 8'h00;
        run_frame(segs_count, 8'hFF, 1'b1, 1'b0, 48, 10, 32'hFFFF_FFFF, -1, 0);
        run_frame(rep8(8'h8E), 8'hFF, 1'b1, 1'b1, 48, -1, 0, -1, 0);

        // Two loads in one frame: one ack, last one wins.
        run_frame(rep8(8'h8E), 8'hFF, 1'b1, 1'b0, 48, 5, 32'h1111_1111, 30, 32'h2222_2222);
        run_frame(rep8(8'hA4), 8'hFF, 1'b1, 1'b1, 48, -1, 0, -1, 0);

        // Alternating digit mask.
        mask = 8'hAA;
        run_frame(rep8(8'hA4), 8'hFF, 1'b1, 1'b0, 48, 3, 32'h2222_2222, -1, 0);
        run_frame(rep8(8'hA4), 8'hAA, 1'b1, 1'b1, 48, -1, 0, -1, 0);

        // Drop en during digit 5 SHOW, then restart from digit 0.
        run_frame(rep8(8'hA4), 8'hAA, 1'b1, 1'b0, 33, -1, 0, -1, 0);
        check("mid_show_sel5", {29'd0, sel}, 32'd5);
        en = 1'b0;
        step();
        check_idle("en_drop");
        step();
        check_idle("en_drop_hold");
        en = 1'b1;
        step();
        run_frame(rep8(8'hA4), 8'hAA, 1'b0, 1'b0, 48, -1, 0, -1, 0);

        // Asynchronous reset mid-scan, while digit 3 is lit.
        run_frame(rep8(8'hA4), 8'hAA, 1'b1, 1'b0, 20, -1, 0, -1, 0);
        check("pre_reset_dig_en", {31'd0, dig_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        #3;
        rst_n = 1'b1;
        step();
        // Active buffer is cleared: zeros shown with every digit masked off.
        run_frame(rep8(8'hC0), 8'h00, 1'b0, 1'b0, 48, -1, 0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scan_display_ctrl.md
# scan_display_ctrl

Time-multiplexed scan controller for an 8-digit common-anode 7-segment display. It sequences the 3-to-8 active-low digit-select decoder by driving its 3-bit select input, and it produces the matching active-low segment pattern for each digit. A guard-blank interval separates digits to prevent ghosting. New display contents are double-buffered and swap only at a frame boundary.

## Interface
- CLK_DIV, 50000: clk cycles each digit is lit (SHOW length); legal range ≥1.
- BLANK_CYCLES, 4: clk cycles of guard blanking before each digit; legal range ≥1.
- DIGITS, 8: digits scanned, sel runs 0..DIGITS-1; legal range 1..8.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  scan enable; 0 forces IDLE.
- data  in  32  hex nibbles; data[4i+3:4i] is shown on digit i.
- dp  in  8  decimal point per digit, 1 = lit.
- mask  in  8  digit enable per digit, 1 = shown, 0 = kept dark.
- load  in  1  one-cycle request to capture data/dp/mask.
- load_ack  out  1  one-cycle pulse when captured values become active.
- sel  out  3  digit index, drives the decoder select input.
- dig_en  out  1  1 = decoder output may drive digit lines; 0 = board gating forces all digits off.
- seg_n  out  8  {~dp, g,f,e,d,c,b,a}, active-low.
- frame_done  out  1  one-cycle pulse after the last digit's SHOW.

## Operation
- The block has three registers: hold (data/dp/mask, 48 bits), active (48 bits), and pending flag.
- A load pulse copies the inputs into hold and sets pending. A later load before the transfer overwrites hold.
- Transfer: active←hold, pending←0, load_ack=1 for one cycle. It occurs in IDLE on the cycle after pending is set, or at a frame boundary.
- States:
  - IDLE: outputs blanked, sel=0. en=1 moves to BLANK.
  - BLANK: BLANK_CYCLES cycles long; seg_n=8'hFF, dig_en=0; then SHOW.
  - SHOW: CLK_DIV cycles long; seg_n={~dp[sel], enc(nibble[sel])}, dig_en=mask[sel]. At the end:
    - If sel<DIGITS-1: sel+1, go to BLANK.
    - Else: sel←0, frame_done=1, transfer if pending, go to BLANK.
- en=0, sampled in any state, gives IDLE on the next cycle. It also sets sel=0, seg_n=FF and dig_en=0, and zeroes the counters. pending and hold are retained.
- enc (active-low g..a), by nibble value:
  - 0 → 40, 1 → 79, 2 → 24, 3 → 30
  - 4 → 19, 5 → 12, 6 → 02, 7 → 78
  - 8 → 00, 9 → 10, A → 08, b → 03
  - C → 46, d → 21, E → 06, F → 0E
- A masked digit keeps seg_n driven normally with dig_en=0. The digit stays dark; sel timing is unchanged.
- Cycle counter width is clog2(max(CLK_DIV, BLANK_CYCLES)). The counter is reused between states and reloads on every state change.

## Timing
- Reset values:
  - Outputs: sel=0, seg_n=8'hFF, dig_en=0, load_ack=0, frame_done=0.
  - Internal: state=IDLE, active=0, hold=0, pending=0.
- All outputs are registered and change only on clk edges, except on asynchronous reset.
- en rising (cycle n) → BLANK from n+1. First SHOW for digit 0 starts at n+1+BLANK_CYCLES.
- Digit period = BLANK_CYCLES+CLK_DIV. Frame period = DIGITS×(BLANK_CYCLES+CLK_DIV).
- frame_done and the boundary load_ack assert in the same cycle as the first BLANK cycle of sel=0.
- The new active values first appear at that frame's first SHOW.
- Frame-boundary transfer uses hold as registered before the boundary edge. A load in the boundary cycle itself stays pending for the next frame.
- load in IDLE (cycle n) → load_ack at n+1.
- A load coinciding with an IDLE transfer leaves pending=1 with the new hold.
- DIGITS=1: every SHOW end is a frame boundary.
- rst_n low mid-scan: immediate return to reset values, no frame_done and no load_ack.

## Test plan
- Bench parameters: CLK_DIV=4, BLANK_CYCLES=2, DIGITS=8.
- Reset, en=1, active=0, mask=FF: sel steps 0..7 every 6 cycles, SHOW seg_n=8'hC0 with dig_en=1, BLANK seg_n=FF. frame_done pulses every 48 cycles.
- IDLE load, data=32'h76543210, dp=8'h01, mask=8'hFF: load_ack next cycle. Then en=1 gives digit 0 seg_n=8'h40 and digit 3 seg_n=8'hB0.
- Mid-frame load of data=32'hFFFFFFFF: display is unchanged until frame_done. load_ack coincides with frame_done. Next frame shows seg_n=8'h8E on all digits.
- Two loads in one frame (first 32'h11111111, then 32'h22222222): one load_ack only, and the next frame shows 8'hA4.
- mask=8'b1010_1010: dig_en=0 during SHOW of even digits, 1 during SHOW of odd digits. Scan cadence is unchanged.
- en dropped at sel=5 mid-SHOW: next cycle IDLE, sel=0, seg_n=FF. Re-enable restarts at digit 0 after 2 BLANK cycles. rst_n pulse mid-scan gives reset values immediately.
